// File: rtl/can_ts_pkg.sv
// Shared definitions for the CAN timestamp block: register map, bit positions, defaults.
package can_ts_pkg;

    localparam int PRESCALE_W_DEF = 16;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_PRESCALE = 6'h04;
    localparam logic [5:0] ADDR_TS_LO    = 6'h08;
    localparam logic [5:0] ADDR_TS_HI    = 6'h0C;
    localparam logic [5:0] ADDR_LOAD_LO  = 6'h10;
    localparam logic [5:0] ADDR_LOAD_HI  = 6'h14;
    localparam logic [5:0] ADDR_ALARM_LO = 6'h18;
    localparam logic [5:0] ADDR_ALARM_HI = 6'h1C;
    localparam logic [5:0] ADDR_STATUS   = 6'h20;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_ALARM_EN = 2;

    localparam int STATUS_ALARM = 0;
    localparam int STATUS_WRAP  = 1;

endpackage

// File: rtl/can_ts_prescaler.sv
// Prescaler for the timestamp counter: one tick every PRESCALE+1 cycles while enabled.
module can_ts_prescaler
    import can_ts_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  pcnt_clr,
    input  logic                  suppress,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;
    logic                  terminal;

    always_comb begin
        terminal = (pcnt_q == prescale);
        // A clear or load on the same edge swallows the tick rather than deferring it.
        tick     = en & terminal & ~suppress;
        pcnt_d   = pcnt_q + 1'b1;
        if (!en || pcnt_clr || terminal) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/can_timestamp_apb.sv
// APB-programmable 64-bit free-running timestamp with compare alarm and atomic high-word readout.
module can_timestamp_apb
    import can_ts_pkg::*;
#(
    parameter int PRESCALE_W   = PRESCALE_W_DEF,
    parameter int PRESCALE_RST = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic [63:0] timestamp,
    output logic        tick,
    output logic        irq
);

    logic                  en_q, en_d;
    logic                  alarm_en_q, alarm_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           load_lo_q, load_lo_d;
    logic [31:0]           load_hi_q, load_hi_d;
    logic [31:0]           alarm_lo_q, alarm_lo_d;
    logic [31:0]           alarm_hi_q, alarm_hi_d;
    logic                  alarm_flag_q, alarm_flag_d;
    logic                  wrap_flag_q, wrap_flag_d;
    logic [31:0]           ts_hi_shadow_q, ts_hi_shadow_d;
    logic [63:0]           count_q, count_d;

    logic       wr, rd;
    logic [5:0] addr;
    logic       wr_ctrl, wr_prescale, wr_load_hi, wr_status;
    logic       clr;
    logic       cnt_adv;
    logic       alarm_set, wrap_set;
    logic       unused_paddr;

    assign wr           = PSEL & PENABLE & PWRITE;
    assign rd           = PSEL & PENABLE & ~PWRITE;
    assign addr         = PADDR[5:0];
    assign unused_paddr = ^PADDR[31:6];
    assign wr_ctrl      = wr & (addr == ADDR_CTRL);
    assign wr_prescale  = wr & (addr == ADDR_PRESCALE);
    assign wr_load_hi   = wr & (addr == ADDR_LOAD_HI);
    assign wr_status    = wr & (addr == ADDR_STATUS);
    assign clr          = wr_ctrl & PWDATA[CTRL_CLR];

    can_ts_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (PCLK),
        .rst      (PRESET),
        .en       (en_q),
        .prescale (prescale_q),
        .pcnt_clr (clr | wr_load_hi | wr_prescale),
        .suppress (clr | wr_load_hi),
        .tick     (tick)
    );

    always_comb begin
        en_d           = en_q;
        alarm_en_d     = alarm_en_q;
        prescale_d     = prescale_q;
        load_lo_d      = load_lo_q;
        load_hi_d      = load_hi_q;
        alarm_lo_d     = alarm_lo_q;
        alarm_hi_d     = alarm_hi_q;
        ts_hi_shadow_d = ts_hi_shadow_q;

        if (wr) begin
            case (addr)
                ADDR_CTRL: begin
                    en_d       = PWDATA[CTRL_EN];
                    alarm_en_d = PWDATA[CTRL_ALARM_EN];
                end
                ADDR_PRESCALE: prescale_d = PWDATA[PRESCALE_W-1:0];
                ADDR_LOAD_LO:  load_lo_d  = PWDATA;
                ADDR_LOAD_HI:  load_hi_d  = PWDATA;
                ADDR_ALARM_LO: alarm_lo_d = PWDATA;
                ADDR_ALARM_HI: alarm_hi_d = PWDATA;
                default: ;
            endcase
        end

        // Latch the pre-update high word so it pairs with the low word being returned.
        if (rd && addr == ADDR_TS_LO) begin
            ts_hi_shadow_d = count_q[63:32];
        end

        count_d = count_q;
        cnt_adv = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (wr_load_hi) begin
            count_d = {PWDATA, load_lo_q};
            cnt_adv = 1'b1;
        end else if (tick) begin
            count_d = count_q + 64'd1;
            cnt_adv = 1'b1;
        end

        alarm_set    = cnt_adv & (count_d == {alarm_hi_q, alarm_lo_q});
        wrap_set     = tick & (&count_q);
        alarm_flag_d = alarm_set | (alarm_flag_q & ~(wr_status & PWDATA[STATUS_ALARM]));
        wrap_flag_d  = wrap_set  | (wrap_flag_q  & ~(wr_status & PWDATA[STATUS_WRAP]));
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q           <= 1'b0;
            alarm_en_q     <= 1'b0;
            prescale_q     <= PRESCALE_W'(PRESCALE_RST);
            load_lo_q      <= '0;
            load_hi_q      <= '0;
            alarm_lo_q     <= '0;
            alarm_hi_q     <= '0;
            alarm_flag_q   <= 1'b0;
            wrap_flag_q    <= 1'b0;
            ts_hi_shadow_q <= '0;
            count_q        <= '0;
        end else begin
            en_q           <= en_d;
            alarm_en_q     <= alarm_en_d;
            prescale_q     <= prescale_d;
            load_lo_q      <= load_lo_d;
            load_hi_q      <= load_hi_d;
            alarm_lo_q     <= alarm_lo_d;
            alarm_hi_q     <= alarm_hi_d;
            alarm_flag_q   <= alarm_flag_d;
            wrap_flag_q    <= wrap_flag_d;
            ts_hi_shadow_q <= ts_hi_shadow_d;
            count_q        <= count_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (addr)
                ADDR_CTRL:     PRDATA = {29'd0, alarm_en_q, 1'b0, en_q};
                ADDR_PRESCALE: PRDATA = 32'(prescale_q);
                ADDR_TS_LO:    PRDATA = count_q[31:0];
                ADDR_TS_HI:    PRDATA = ts_hi_shadow_q;
                ADDR_LOAD_LO:  PRDATA = load_lo_q;
                ADDR_LOAD_HI:  PRDATA = load_hi_q;
                ADDR_ALARM_LO: PRDATA = alarm_lo_q;
                ADDR_ALARM_HI: PRDATA = alarm_hi_q;
                ADDR_STATUS:   PRDATA = {30'd0, wrap_flag_q, alarm_flag_q};
                default:       PRDATA = '0;
            endcase
        end
    end

    assign PREADY    = 1'b1;
    assign timestamp = count_q;
    assign irq       = alarm_flag_q & alarm_en_q;

endmodule

// File: tb/tb_can_timestamp_apb.sv
// Directed bench for can_timestamp_apb: APB access tasks, hand-computed expectations.
module tb_can_timestamp_apb;
    import can_ts_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [63:0] timestamp;
    logic        tick, irq;

    int n_checks = 0;
    int n_errors = 0;

    can_timestamp_apb #(
        .PRESCALE_W   (16),
        .PRESCALE_RST (0)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .timestamp (timestamp),
        .tick      (tick),
        .irq       (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Write lands on the third rising edge after the call; returns 1 time unit after it.
    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {26'd0, a}; PWDATA = d;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {26'd0, a};
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        d = PRDATA;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          ticks;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        step(3);
        PRESET = 1'b0;
        step(1);

        // Reset state
        check("rst_ts", timestamp, 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("pready", 64'(PREADY), 64'd1);
        apb_read(ADDR_CTRL, r);      check("rst_ctrl", 64'(r), 64'd0);
        apb_read(ADDR_PRESCALE, r);  check("rst_prescale", 64'(r), 64'd0);
        apb_read(ADDR_STATUS, r);    check("rst_status", 64'(r), 64'd0);
        apb_read(ADDR_TS_HI, r);     check("rst_ts_hi", 64'(r), 64'd0);
        apb_write(6'h24, 32'hFFFF_FFFF);
        apb_read(6'h24, r);          check("unmapped", 64'(r), 64'd0);

        // Prescale 3: tick every 4th cycle, 5 increments over 20 cycles
        apb_write(ADDR_PRESCALE, 32'd3);
        apb_read(ADDR_PRESCALE, r);  check("prescale_rb", 64'(r), 64'd3);
        apb_write(ADDR_CTRL, 32'h1);
        ticks = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge PCLK);
            #1;
            if (tick) ticks++;
            if (i == 3) check("ps3_tick_c3", 64'(tick), 64'd1);
            if (i == 4) check("ps3_ts_c4", timestamp, 64'd1);
        end
        check("ps3_ticks", 64'(ticks), 64'd5);
        check("ps3_ts_c20", timestamp, 64'd5);
        apb_write(ADDR_CTRL, 32'h0);
        check("dis_ts", timestamp, 64'd5);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check("dis_ticks", 64'(ticks), 64'd0);
        check("dis_ts_hold", timestamp, 64'd5);

        // Load near the top while disabled, then wrap
        apb_write(ADDR_ALARM_HI, 32'h1234);
        apb_write(ADDR_LOAD_LO, 32'hFFFF_FFFE);
        apb_write(ADDR_LOAD_HI, 32'hFFFF_FFFF);
        check("load_dis", timestamp, 64'hFFFF_FFFF_FFFF_FFFE);
        apb_write(ADDR_PRESCALE, 32'd0);
        apb_write(ADDR_CTRL, 32'h1);
        step(1); check("wrap_ff", timestamp, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1); check("wrap_0", timestamp, 64'd0);
        apb_write(ADDR_CTRL, 32'h0);
        apb_read(ADDR_STATUS, r);    check("wrap_status", 64'(r), 64'h2);
        check("wrap_irq", 64'(irq), 64'd0);
        apb_write(ADDR_STATUS, 32'h3);
        apb_read(ADDR_STATUS, r);    check("w1c_status", 64'(r), 64'h0);

        // Alarm at 10
        apb_write(ADDR_ALARM_HI, 32'd0);
        apb_write(ADDR_ALARM_LO, 32'd10);
        apb_write(ADDR_CTRL, 32'h6);
        check("clr_ts", timestamp, 64'd0);
        apb_write(ADDR_CTRL, 32'h5);
        step(9);
        check("alm_ts9", timestamp, 64'd9);
        check("alm_irq9", 64'(irq), 64'd0);
        step(1);
        check("alm_ts10", timestamp, 64'd10);
        check("alm_irq10", 64'(irq), 64'd1);
        apb_read(ADDR_STATUS, r);    check("alm_status", 64'(r), 64'h1);
        check("alm_irq_hold", 64'(irq), 64'd1);
        apb_write(ADDR_STATUS, 32'h1);
        check("alm_w1c_irq", 64'(irq), 64'd0);

        // Alarm from load with ALARM_EN off; load beats tick on the same edge
        apb_write(ADDR_CTRL, 32'h1);
        apb_write(ADDR_LOAD_LO, 32'd10);
        apb_write(ADDR_LOAD_HI, 32'd0);
        check("load_vs_tick", timestamp, 64'd10);
        check("noen_irq", 64'(irq), 64'd0);
        step(1);
        check("load_next", timestamp, 64'd11);
        apb_read(ADDR_STATUS, r);    check("noen_status", 64'(r), 64'h1);

        // Alarm register write matching the idle counter must not set the flag
        apb_write(ADDR_CTRL, 32'h2);
        check("clr_idle", timestamp, 64'd0);
        apb_write(ADDR_STATUS, 32'h3);
        apb_write(ADDR_ALARM_LO, 32'd0);
        apb_read(ADDR_STATUS, r);    check("alm_wr_nomatch", 64'(r), 64'h0);

        // Clear beats tick; CLR bit reads back 0
        apb_write(ADDR_ALARM_HI, 32'hABCD);
        apb_write(ADDR_CTRL, 32'h1);
        step(3);
        check("run_ts3", timestamp, 64'd3);
        apb_write(ADDR_CTRL, 32'h3);
        check("clr_vs_tick", timestamp, 64'd0);
        apb_read(ADDR_CTRL, r);      check("ctrl_clr_rb", 64'(r), 64'h1);

        // PRESCALE rewrite restarts the period
        apb_write(ADDR_CTRL, 32'h3);
        apb_write(ADDR_PRESCALE, 32'd4);
        check("ps_wr_ts", timestamp, 64'd3);
        step(4);
        check("ps_wr_ts_p4", timestamp, 64'd3);
        check("ps_wr_tick_p4", 64'(tick), 64'd1);
        step(1);
        check("ps_wr_ts_p5", timestamp, 64'd4);

        // Shadowed high word
        apb_write(ADDR_CTRL, 32'h0);
        apb_write(ADDR_PRESCALE, 32'd0);
        apb_write(ADDR_LOAD_LO, 32'hFFFF_FFFF);
        apb_write(ADDR_LOAD_HI, 32'd0);
        apb_read(ADDR_TS_LO, r);     check("shd_lo", 64'(r), 64'hFFFF_FFFF);
        apb_write(ADDR_CTRL, 32'h1);
        step(3);
        check("shd_live_hi", {32'd0, timestamp[63:32]}, 64'd1);
        apb_read(ADDR_TS_HI, r);     check("shd_hi", 64'(r), 64'd0);

        // TS_LO read on the same edge as the carry into the high word
        apb_write(ADDR_LOAD_LO, 32'hFFFF_FFFD);
        apb_write(ADDR_LOAD_HI, 32'd0);
        check("shd2_load", timestamp, 64'h0000_0000_FFFF_FFFD);
        apb_read(ADDR_TS_LO, r);     check("shd2_lo", 64'(r), 64'hFFFF_FFFF);
        apb_read(ADDR_TS_HI, r);     check("shd2_hi", 64'(r), 64'd0);
        check("shd2_live_hi", {32'd0, timestamp[63:32]}, 64'd1);

        // Asynchronous reset mid-count with irq high
        apb_write(ADDR_ALARM_HI, 32'd0);
        apb_write(ADDR_ALARM_LO, 32'd3);
        apb_write(ADDR_CTRL, 32'h7);
        step(3);
        check("pre_rst_ts", timestamp, 64'd3);
        check("pre_rst_irq", 64'(irq), 64'd1);
        check("pre_rst_tick", 64'(tick), 64'd1);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'(ADDR_CTRL);
        #1;
        check("pre_rst_ctrl", 64'(PRDATA), 64'h5);
        #1;
        PRESET = 1'b1;
        #1;
        check("arst_ts", timestamp, 64'd0);
        check("arst_irq", 64'(irq), 64'd0);
        check("arst_tick", 64'(tick), 64'd0);
        check("arst_ctrl", 64'(PRDATA), 64'd0);
        PSEL = 1'b0;
        step(1);
        PRESET = 1'b0;
        step(5);
        check("post_rst_ts", timestamp, 64'd0);
        check("post_rst_tick", 64'(tick), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/can_timestamp_apb.md
Name: can_timestamp_apb

Overview:
- APB-programmable 64-bit free-running timestamp generator.
- Drives the timestamp input of the CAN controller's APB wrapper, replacing the current constant tie-off, so received and transmitted frames carry real time.
- Sits on the same APB segment as the CAN controller and adds a compare-alarm interrupt.
- Provides an atomic 64-bit readout through a shadow-latched high word.

Parameters:
- PRESCALE_W, 16, width of the prescaler divider register.
- PRESCALE_RST, 0, reset value of PRESCALE; tick period = PRESCALE+1 PCLK cycles.

Ports:
- PCLK  in  1  system clock; single clock domain.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  APB direction, 1 = write.
- PADDR  in  32  byte address; only [5:0] decoded.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied 1; no wait states.
- timestamp  out  64  current count; connects directly to the CAN controller timestamp input.
- tick  out  1  one-cycle pulse on each count increment.
- irq  out  1  level interrupt = STATUS.ALARM & CTRL.ALARM_EN.

Behaviour:
- Registers (offset, access):
  - 0x00 CTRL (RW): [0] EN, [1] CLR (write-1 pulse, reads 0), [2] ALARM_EN.
  - 0x04 PRESCALE (RW): [PRESCALE_W-1:0].
  - 0x08 TS_LO (RO): reading latches count[63:32] into the TS_HI shadow.
  - 0x0C TS_HI (RO): returns the shadow.
  - 0x10 LOAD_LO (RW).
  - 0x14 LOAD_HI (RW): writing it loads {LOAD_HI, LOAD_LO} into the counter.
  - 0x18 ALARM_LO (RW), 0x1C ALARM_HI (RW).
  - 0x20 STATUS (W1C): [0] ALARM, [1] WRAP.
  - Unmapped addresses: read 0, writes ignored.
- Writes take effect on the PCLK edge where PSEL & PENABLE & PWRITE are all high.
- Reads:
  - PRDATA is combinational from PADDR whenever PSEL=1, valid in both setup and access phases.
  - The TS_LO shadow-latch side effect happens only on the access-phase edge (PSEL & PENABLE & ~PWRITE).
- Reset values:
  - All registers 0 except PRESCALE = PRESCALE_RST.
  - timestamp = 0, tick = 0, irq = 0, prescaler counter = 0.
- Prescaler (pcnt):
  - When EN=1: pcnt increments each cycle. When pcnt == PRESCALE, tick=1 for that cycle, pcnt returns to 0, and the counter increments on the same edge.
  - PRESCALE=0 gives a tick on every cycle.
  - When EN=0: pcnt is held at 0, tick=0, counter holds.
  - A write to PRESCALE clears pcnt on the same edge; the new period starts from the following cycle.
- Counter update priority, highest first:
  1. CLR: counter and pcnt go to 0.
  2. LOAD_HI write: counter = {PWDATA, LOAD_LO}; pcnt goes to 0.
  3. tick: counter + 1.
  - A suppressed tick is lost, not deferred.
  - Load is honoured even when EN=0.
- timestamp output is the counter register: latency 1 cycle after a tick, load or clear.
- Wrap: a tick at 0xFFFF_FFFF_FFFF_FFFF sets the counter to 0 and sets STATUS.WRAP.
- Alarm:
  - STATUS.ALARM is set on the edge where the counter's next value equals {ALARM_HI, ALARM_LO} and that next value results from a tick or load.
  - Clear and idle cycles never trigger it.
  - A match caused by a register write to ALARM_* does not set the flag.
- STATUS flags:
  - Flags are sticky.
  - If a W1C clear and a set land on the same edge, set wins.
  - irq deasserts the cycle after W1C, unless re-set on that edge.
- TS_HI shadow:
  - Updates only on a TS_LO read; unaffected by counter roll-over between the two reads.
  - A TS_LO read on the same edge as an increment latches the pre-increment high word, consistent with the returned TS_LO.
- Reset asserted mid-operation asynchronously clears all state; counting resumes only after software sets EN.

Decomposition:
- Shared package can_ts_pkg:
  - register offsets (CTRL, PRESCALE, TS_LO, TS_HI, LOAD_LO, LOAD_HI, ALARM_LO, ALARM_HI, STATUS);
  - CTRL/STATUS bit indices;
  - PRESCALE_W default.
- One natural sub-module: can_ts_prescaler, containing pcnt, the tick generator and the clear-on-write/clear-on-load logic.
- APB decode, registers, counter and alarm stay in the top level.

Test Plan:
- Reset with PRESCALE=3, EN=1 written -> tick every 4th cycle; timestamp reads 5 after 20 cycles; tick low while EN=0.
- Load LOAD_LO=0xFFFF_FFFE, LOAD_HI=0xFFFF_FFFF, PRESCALE=0, EN=1 -> timestamp steps ...FE, ...FF, then 0; STATUS=0x2.
- ALARM={0,10}, ALARM_EN=1, PRESCALE=0, CLR then EN -> irq rises the cycle timestamp becomes 10; W1C 0x1 to STATUS -> irq low next cycle; ALARM_EN=0 -> irq stays low with flag set.
- Counter loaded to 0x0000_0000_FFFF_FFFF, read TS_LO then TS_HI with ticks between -> pair returns {0x0,0xFFFF_FFFF}, not {0x1,0xFFFF_FFFF}.
- Same-edge CLR and LOAD_HI write -> timestamp=0. Same-edge tick and LOAD -> loaded value, no increment. PRESCALE rewrite mid-count -> next tick exactly PRESCALE+1 cycles later.
- Assert PRESET mid-count with irq high -> timestamp, irq, tick, PRDATA of CTRL all 0 immediately, without waiting for a clock edge.
